// File: rtl/ysyx_23060180_pkg.sv
// ysyx_23060180_pkg: shared core constants, memory response type and address-offset helper.
package ysyx_23060180_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;

   typedef struct packed {
      logic            valid;
      logic            err;
      logic [XLEN-1:0] data;
   } mem_resp_t;

   // 33-bit offset so that an address below base shows up as a huge value.
   function automatic logic [XLEN:0] byte_off(input logic [XLEN-1:0] a, input logic [XLEN-1:0] base);
      return {1'b0, a} - {1'b0, base};
   endfunction

endpackage

// File: rtl/ysyx_23060180_mem_responder_if.sv
// ysyx_23060180_mem_responder_if: read/write bus between the core and the memory responder.
interface ysyx_23060180_mem_responder_if
   import ysyx_23060180_pkg::*;
   ;
   logic            mem_rd;
   logic [XLEN-1:0] mem_raddr;
   logic [XLEN-1:0] mem_rdata;
   logic            mem_rvalid;
   logic            mem_rerr;
   logic            mem_wr;
   logic [XLEN-1:0] mem_waddr;
   logic [XLEN-1:0] mem_wdata;
   logic [3:0]      mem_wstrb;

   modport master (
      output mem_rd, mem_raddr, mem_wr, mem_waddr, mem_wdata, mem_wstrb,
      input  mem_rdata, mem_rvalid, mem_rerr
   );

   modport slave (
      input  mem_rd, mem_raddr, mem_wr, mem_waddr, mem_wdata, mem_wstrb,
      output mem_rdata, mem_rvalid, mem_rerr
   );

endinterface

// File: rtl/ysyx_23060180_resp_pipe.sv
// ysyx_23060180_resp_pipe: fixed-depth delay line of memory responses with asynchronous clear.
module ysyx_23060180_resp_pipe
   import ysyx_23060180_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic      clk,
   input  logic      rstn_in,
   input  mem_resp_t resp_i,
   output mem_resp_t resp_o
);

   mem_resp_t [DEPTH-1:0] pipe_q, pipe_d;

   always_comb begin
      pipe_d[0] = resp_i;
      for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
   end

   always_ff @(posedge clk or negedge rstn_in)
      if (!rstn_in) pipe_q <= '0;
      else pipe_q <= pipe_d;

   assign resp_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/ysyx_23060180_mem_responder.sv
// ysyx_23060180_mem_responder: word RAM at BASE_ADDR answering reads after LATENCY cycles,
// with a byte-strobed write port; out-of-window or misaligned accesses are rejected.
module ysyx_23060180_mem_responder
   import ysyx_23060180_pkg::*;
#(
   parameter logic [XLEN-1:0] BASE_ADDR   = RESET_PC,
   parameter int              DEPTH_WORDS = 4096,
   parameter int              LATENCY     = 1
) (
   input logic                           clk,
   input logic                           rstn_in,
   ysyx_23060180_mem_responder_if.slave  bus
);

   localparam int            AW    = $clog2(DEPTH_WORDS);
   localparam logic [XLEN:0] BYTES = (XLEN+1)'(DEPTH_WORDS) << 2;

   logic [XLEN-1:0] mem_q [DEPTH_WORDS];
   logic [XLEN:0]   rdiff, wdiff;
   logic            rd_ok, wr_ok;
   mem_resp_t       req_d, rsp_q;

   // A below-base address borrows into bit XLEN, so one compare covers both bounds.
   assign rdiff = byte_off(bus.mem_raddr, BASE_ADDR);
   assign wdiff = byte_off(bus.mem_waddr, BASE_ADDR);
   assign rd_ok = bus.mem_raddr[1:0] == 2'b00 && rdiff < BYTES;
   assign wr_ok = bus.mem_waddr[1:0] == 2'b00 && wdiff < BYTES;

   // Array is read before this edge's write lands, giving read-before-write.
   always_comb begin
      req_d.valid = bus.mem_rd;
      req_d.err   = bus.mem_rd && !rd_ok;
      req_d.data  = (bus.mem_rd && rd_ok) ? mem_q[rdiff[AW+1:2]] : '0;
   end

   always_ff @(posedge clk)
      if (bus.mem_wr && wr_ok)
         for (int b = 0; b < 4; b++)
            if (bus.mem_wstrb[b]) mem_q[wdiff[AW+1:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];

   ysyx_23060180_resp_pipe #(.DEPTH(LATENCY)) u_pipe (
      .clk     (clk),
      .rstn_in (rstn_in),
      .resp_i  (req_d),
      .resp_o  (rsp_q)
   );

   assign bus.mem_rvalid = rsp_q.valid;
   assign bus.mem_rerr   = rsp_q.err;
   assign bus.mem_rdata  = rsp_q.data;

endmodule

// File: tb/tb_ysyx_23060180_mem_responder.sv
// tb_ysyx_23060180_mem_responder: directed checks of three responders (LATENCY 1, 3, 4)
// driven by one shared stimulus stream.
module tb_ysyx_23060180_mem_responder;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        rd = 1'b0, wr = 1'b0;
   logic [31:0] raddr = '0, waddr = '0, wdata = '0;
   logic [3:0]  wstrb = '0;
   int          tests = 0, fails = 0;

   always #5 clk = ~clk;

   ysyx_23060180_mem_responder_if if1 ();
   ysyx_23060180_mem_responder_if if3 ();
   ysyx_23060180_mem_responder_if if4 ();

   assign {if1.mem_rd, if1.mem_raddr, if1.mem_wr, if1.mem_waddr, if1.mem_wdata, if1.mem_wstrb} = {rd, raddr, wr, waddr, wdata, wstrb};
   assign {if3.mem_rd, if3.mem_raddr, if3.mem_wr, if3.mem_waddr, if3.mem_wdata, if3.mem_wstrb} = {rd, raddr, wr, waddr, wdata, wstrb};
   assign {if4.mem_rd, if4.mem_raddr, if4.mem_wr, if4.mem_waddr, if4.mem_wdata, if4.mem_wstrb} = {rd, raddr, wr, waddr, wdata, wstrb};

   ysyx_23060180_mem_responder #(.LATENCY(1)) u1 (.clk(clk), .rstn_in(rstn), .bus(if1.slave));
   ysyx_23060180_mem_responder #(.LATENCY(3)) u3 (.clk(clk), .rstn_in(rstn), .bus(if3.slave));
   ysyx_23060180_mem_responder #(.LATENCY(4)) u4 (.clk(clk), .rstn_in(rstn), .bus(if4.slave));

   function automatic logic [33:0] r1(); return {if1.mem_rvalid, if1.mem_rerr, if1.mem_rdata}; endfunction
   function automatic logic [33:0] r3(); return {if3.mem_rvalid, if3.mem_rerr, if3.mem_rdata}; endfunction
   function automatic logic [33:0] r4(); return {if4.mem_rvalid, if4.mem_rerr, if4.mem_rdata}; endfunction

   function automatic logic [33:0] ok(input logic [31:0] d); return {2'b10, d}; endfunction

   localparam logic [33:0] IDLE = 34'h0;
   localparam logic [33:0] ERR  = {2'b11, 32'h0};

   task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed {v,e,d}=%h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      wr = 1'b1; waddr = a; wdata = d; wstrb = s;
      tick();
      wr = 1'b0; wstrb = '0;
   endtask

   task automatic rd_word(input logic [31:0] a);
      rd = 1'b1; raddr = a;
      tick();
      rd = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      chk("reset_u1", r1(), IDLE);
      chk("reset_u3", r3(), IDLE);
      chk("reset_u4", r4(), IDLE);
      rstn = 1'b1;

      // write then read, latency seen on all three instances
      wr_word(32'h8000_0000, 32'hDEAD_BEEF, 4'hF);
      rd_word(32'h8000_0000);
      chk("wr_rd_u1", r1(), ok(32'hDEAD_BEEF));
      chk("wr_rd_u3_early", r3(), IDLE);
      tick();
      chk("wr_rd_u1_single", r1(), IDLE);
      tick();
      chk("wr_rd_u3", r3(), ok(32'hDEAD_BEEF));
      tick();
      chk("wr_rd_u4", r4(), ok(32'hDEAD_BEEF));

      // byte strobes and zero strobe
      wr_word(32'h8000_0004, 32'h1122_3344, 4'hF);
      wr_word(32'h8000_0004, 32'hAABB_CCDD, 4'b0101);
      rd_word(32'h8000_0004);
      chk("strb_0101", r1(), ok(32'h11BB_33DD));
      wr_word(32'h8000_0004, 32'hFFFF_FFFF, 4'b0000);
      rd_word(32'h8000_0004);
      chk("strb_0000", r1(), ok(32'h11BB_33DD));

      // back-to-back reads
      for (int i = 0; i < 8; i++) wr_word(32'h8000_0000 + 4*i, 32'hA000_0000 + i, 4'hF);
      for (int c = 0; c < 12; c++) begin
         rd = c < 8;
         raddr = 32'h8000_0000 + 4*c;
         tick();
         chk($sformatf("b2b_u1_%0d", c), r1(), c < 8 ? ok(32'hA000_0000 + c) : IDLE);
         chk($sformatf("b2b_u3_%0d", c), r3(), (c >= 2 && c < 10) ? ok(32'hA000_0000 + c - 2) : IDLE);
         chk($sformatf("b2b_u4_%0d", c), r4(), (c >= 3 && c < 11) ? ok(32'hA000_0000 + c - 3) : IDLE);
      end
      rd = 1'b0;

      // error responses and a dropped illegal write
      rd_word(32'h8000_0002);
      chk("err_misaligned", r1(), ERR);
      rd_word(32'h7FFF_FFFC);
      chk("err_below", r1(), ERR);
      rd_word(32'h8000_4000);
      chk("err_above", r1(), ERR);
      rd_word(32'h8000_3FFC);
      chk("last_word_legal", r1(), {2'b10, r1_last_data()});
      wr_word(32'h8000_0002, 32'hFFFF_FFFF, 4'hF);
      rd_word(32'h8000_0000);
      chk("illegal_wr_dropped", r1(), ok(32'hA000_0000));

      // same-edge read and write
      wr_word(32'h8000_0008, 32'h0BAD_F00D, 4'hF);
      rd = 1'b1; raddr = 32'h8000_0008;
      wr = 1'b1; waddr = 32'h8000_0008; wdata = 32'h1234_5678; wstrb = 4'hF;
      tick();
      wr = 1'b0;
      chk("rbw_old", r1(), ok(32'h0BAD_F00D));
      tick();
      rd = 1'b0;
      chk("rbw_new", r1(), ok(32'h1234_5678));

      // reset mid-flight
      repeat (5) tick();
      rd_word(32'h8000_0000);
      rd_word(32'h8000_0004);
      chk("rst_pre_u1", r1(), ok(32'hA000_0001));
      tick();
      chk("rst_pre_u3", r3(), ok(32'hA000_0000));
      rstn = 1'b0;
      #1;
      chk("rst_async_u1", r1(), IDLE);
      chk("rst_async_u3", r3(), IDLE);
      chk("rst_async_u4", r4(), IDLE);
      tick();
      tick();
      chk("rst_hold_u4", r4(), IDLE);
      rstn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("rst_drop_u4_%0d", i), r4(), IDLE);
      end
      rd_word(32'h8000_0004);
      chk("rst_persist", r1(), ok(32'hA000_0001));
      rd_word(32'h8000_0008);
      chk("rst_persist2", r1(), ok(32'h1234_5678));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // The last word is never written before its read, so only validity and err are fixed;
   // reuse the observed data so the check targets the legality decision at the top edge.
   function automatic logic [31:0] r1_last_data(); return if1.mem_rdata; endfunction

endmodule

// File: doc/ysyx_23060180_mem_responder.md
# ysyx_23060180_mem_responder

Memory-side responder for the CPU core's fetch/load port. It holds a word-addressed RAM mapped at the reset PC and answers `mem_rd` requests after a fixed, parameterised latency with a `mem_rvalid` strobe. It also provides a byte-strobed write port for the loader and store path. It sits between the core and the simulation top, replacing the testbench-side combinational memory.

## Interface
- `BASE_ADDR`, default 32'h80000000: byte address of word 0.
- `DEPTH_WORDS`, default 4096: number of 32-bit words; power of two.
- `LATENCY`, default 1: read latency in cycles; legal range 1..4.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rstn_in` in 1: reset, asynchronous and active-low.
- `mem_rd` in 1: read request, sampled each rising edge.
- `mem_raddr` in 32: read byte address.
- `mem_rdata` out 32: read data; valid only while `mem_rvalid`=1.
- `mem_rvalid` out 1: read response strobe, one cycle per accepted request.
- `mem_rerr` out 1: response error; qualified by `mem_rvalid`.
- `mem_wr` in 1: write request.
- `mem_waddr` in 32: write byte address.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: byte enables; bit i writes byte lane i.

## Operation
- Request acceptance:
  - Every rising edge with `mem_rd`=1 accepts one read. There is no backpressure; back-to-back reads are fully pipelined.
- Address check:
  - A request is legal iff `mem_raddr[1:0]`==0 and `BASE_ADDR` <= `mem_raddr` < `BASE_ADDR` + 4*`DEPTH_WORDS`.
  - Word index is (`mem_raddr` - `BASE_ADDR`)>>2, truncated to log2(`DEPTH_WORDS`) bits.
- Response content:
  - Legal read: `mem_rdata` = array word, `mem_rerr`=0.
  - Illegal read: `mem_rdata`=32'h0, `mem_rerr`=1, and the array is not accessed.
- Writes:
  - A write is performed in the accepting cycle under the same legality check; illegal writes are silently dropped.
  - `mem_wstrb`=4'b0000 is a no-op.
- Simultaneous read and write, same word, same edge: the read returns the pre-write data (read-before-write).
- Pipeline structure:
  - A shift pipeline of depth `LATENCY` carries {valid, err, data}. Data is captured from the array at the accepting edge; stages 2..`LATENCY` are pure delay.
- Reset behaviour:
  - Reset clears every pipeline valid, err and data bit.
  - Reset does not clear array contents; array contents are undefined until written.
  - Reset asserted mid-operation drops all in-flight responses: no `mem_rvalid` after reset release for requests accepted before reset.

## Timing
- Reset values: `mem_rvalid`=0, `mem_rerr`=0, `mem_rdata`=32'h0.
- Read latency: a request sampled at edge k produces `mem_rvalid`=1 in the cycle after edge k+`LATENCY`-1. With `LATENCY`=1, that is the cycle directly after the sampling edge.
- Response order equals request order. Exactly one response strobe per accepted request, with no merging or gaps introduced by the block.
- Write visibility:
  - A write at edge k is visible to reads sampled at edge k+1 and later.
  - A read sampled at edge k sees the old data.
- Outputs are registered, with no combinational path from any input to any output.
- With `LATENCY`=1, the first request may be sampled at the first edge after `rstn_in` rises.

## Structure
- Shared package `ysyx_23060180_pkg`: `XLEN`=32, `RESET_PC`=32'h80000000 (default for `BASE_ADDR`), and the typedef `mem_resp_t` {valid, err, data[31:0]}.
- Sub-module `ysyx_23060180_resp_pipe`: a parameterised delay line of `mem_resp_t` with asynchronous clear.
- The top level contains the array, the address check, the write logic and one `ysyx_23060180_resp_pipe` instance.

## Test plan
- Write then read:
  - Stimulus: write 32'hDEADBEEF to 32'h80000000 with strb 4'hF, then read 32'h80000000 at `LATENCY`=1.
  - Required: `mem_rvalid`=1 one cycle after the sampling edge, `mem_rdata`=32'hDEADBEEF, `mem_rerr`=0.
- Byte strobes:
  - Stimulus: preload 32'h11223344, write 32'hAABBCCDD with strb 4'b0101, then read.
  - Required: 32'h11BB33DD.
- Back-to-back reads:
  - Stimulus: 8 consecutive read cycles over 32'h80000000..32'h8000001C at `LATENCY`=3.
  - Required: 8 consecutive `mem_rvalid` cycles starting 3 cycles after the first request, data in address order.
- Error responses:
  - Stimulus: reads at 32'h80000002, 32'h7FFFFFFC and 32'h80000000 + 4*`DEPTH_WORDS`.
  - Required: each returns `mem_rerr`=1 and `mem_rdata`=0.
  - Stimulus: a write to 32'h80000002.
  - Required: the write leaves the array unchanged.
- Same-edge read and write:
  - Stimulus: a read and a write of 32'h12345678 to the same word on the same edge, where the old value is 32'h0BADF00D.
  - Required: the read returns 32'h0BADF00D; the next read returns 32'h12345678.
- Reset mid-flight:
  - Stimulus: at `LATENCY`=4, issue 2 reads, then assert `rstn_in` 1 cycle later for 2 cycles.
  - Required: outputs go to reset values immediately on assertion, no `mem_rvalid` ever appears for the dropped requests, and array contents persist.
